boot_rom_fetch: RTL and testbench
=================================

# boot_rom_fetch

Single-word prefetching read port between the CPU instruction-fetch bus and the bootloader ROM (`boot_rom`). It accepts word fetches with a request/acknowledge handshake and drives the ROM's synchronous read port, which has a 1-cycle read latency. It returns ROM data and keeps a one-entry buffer holding the next sequential word. Sequential fetches, which are the bootloader's common case, therefore complete with 1-cycle latency instead of 2.

## Interface
- `ADDR_W`, 9, ROM word-address width (512 x 32-bit words).

- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  synchronous active-high reset.
- `i_req`  in  1  fetch request; held high with a stable `i_addr` until `o_ack`.
- `i_addr`  in  32  byte address; only bits `[ADDR_W+1:0]` are used, higher bits are decoded upstream.
- `o_ack`  out  1  one-cycle pulse; `o_data`/`o_err` are valid in this cycle.
- `o_data`  out  32  fetched word (registered).
- `o_err`  out  1  misaligned fetch, valid with `o_ack` (registered).
- `o_rom_addr`  out  ADDR_W  word address to the ROM (combinational from state).
- `i_rom_data`  in  32  ROM read data; valid 1 cycle after `o_rom_addr` is sampled.

## Operation
- Word index: W = `i_addr[ADDR_W+1:2]`.
- Prefetch tag: `buf_tag`. Next address `buf_tag+1` wraps mod 2^ADDR_W, so 511 -> 0.
- Buffer registers: `buf_valid`, `buf_tag`, `buf_data`.
- States: IDLE, MISS, PF.
- A request is accepted only in IDLE with `i_req`=1 and `o_ack`=0. A still-high `i_req` in the ack cycle is ignored.

IDLE behaviour:
- Misaligned (`i_addr[1:0]`!=0): next cycle `o_ack`=1, `o_err`=1, `o_data`=0. No ROM access, buffer untouched, stay IDLE.
- Hit (`buf_valid` && `buf_tag`==W):
  - `o_data`<=`buf_data`; `o_ack` next cycle.
  - `o_rom_addr`=W+1 this cycle; `buf_tag`<=W+1; go to PF.
- Miss:
  - `o_rom_addr`=W; `buf_tag`<=W+1; `buf_valid`<=0; go to MISS.
- No request: `o_rom_addr`=W (don't-care), stay IDLE.

MISS behaviour:
- `o_data`<=`i_rom_data`; `o_ack` next cycle.
- `o_rom_addr`=`buf_tag` (W+1); go to PF.

PF behaviour:
- `buf_data`<=`i_rom_data`; `buf_valid`<=1.
- `o_rom_addr`=`buf_tag`; go to IDLE.

Reset:
- State IDLE; `buf_valid`=0, `buf_tag`=0, `buf_data`=0; `o_ack`=0, `o_err`=0, `o_data`=0.
- A request in flight at reset is dropped with no ack; the requester reissues it.
- The reset has no effect on ROM contents.

## Timing
- Miss: request in c0 -> `o_ack` in c2 (latency 2). Prefetch of W+1 is issued in c1 and the buffer is valid from c3.
- Hit: request in c0 -> `o_ack` in c1 (latency 1). Prefetch of W+1 is issued in c0 and the buffer is refreshed at the end of c1.
- Misaligned: `o_ack`+`o_err` in c1.
- Sequential stream after the first word: one word per 2 cycles.
- `o_ack` is never high in two consecutive cycles.
- A request presented while in MISS/PF is held by the requester and accepted on the first IDLE cycle with `o_ack`=0.
- `o_rom_addr` is combinational; the ROM registers it on the same edge on which the state advances.

## Test plan
- Reset, then fetch 0x000 (ROM[0]=0x00008137) -> `o_ack` at c2, `o_data`=0x00008137, `o_err`=0. Then fetch 0x004 -> ack 1 cycle after acceptance, `o_data`=0x01012183.
- Stream addresses 0x000..0x03C -> 16 acks with data matching the ROM image. After the first word, acks arrive every 2 cycles.
- Fetch 0x7FC (word 511), then 0x000 -> the second fetch hits the wrapped prefetch (latency 1) and returns ROM[0].
- Fetch 0x002 -> `o_ack`=1, `o_err`=1, `o_data`=0 at c1. The next fetch of the previously buffered address still hits.
- Fetch 0x010, then non-sequential 0x100 -> the second fetch misses (latency 2) and returns ROM[0x40]. Hold `i_req` high through the ack cycle -> no duplicate ack.
- Assert `i_rst` during MISS -> no `o_ack`; all outputs 0 the next cycle; the reissued fetch misses with latency 2.

Source files
------------

// File: rtl/boot_rom_fetch.sv
// Instruction-fetch read port for the boot ROM with a one-word sequential prefetch buffer.
// Sequential fetches hit the buffer and are acknowledged one cycle after acceptance.
//
// state | meaning
// IDLE  | waiting for a fetch; a hit or aligned miss issues a ROM read this cycle
// MISS  | ROM returns the requested word; the prefetch of W+1 is issued
// PF    | ROM returns the prefetched word, which is captured into the buffer
module boot_rom_fetch #(
    parameter int ADDR_W = 9
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              o_ack,
    output logic [31:0]       o_data,
    output logic              o_err,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [31:0]       i_rom_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MISS = 2'd1,
        PF   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic              buf_valid;
    logic [ADDR_W-1:0] buf_tag;
    logic [31:0]       buf_data;

    logic [ADDR_W-1:0] word_idx;
    logic [ADDR_W-1:0] word_nxt;
    logic              accept;
    logic              misaligned;
    logic              hit;

    // Address bits above the ROM window are decoded upstream.
    logic unused_addr_hi;
    assign unused_addr_hi = ^i_addr[31:ADDR_W+2];

    assign word_idx   = i_addr[ADDR_W+1:2];
    assign word_nxt   = word_idx + ADDR_W'(1);
    assign misaligned = (i_addr[1:0] != 2'b00);
    assign hit        = buf_valid && (buf_tag == word_idx);
    // The ack cycle never accepts, so a request held through it is not duplicated.
    assign accept     = (state == IDLE) && i_req && !o_ack;

    always_comb begin
        state_nxt  = state;
        o_rom_addr = word_idx;
        case (state)
            IDLE: begin
                if (accept && !misaligned) begin
                    if (hit) begin
                        o_rom_addr = word_nxt;
                        state_nxt  = PF;
                    end else begin
                        state_nxt  = MISS;
                    end
                end
            end
            MISS: begin
                o_rom_addr = buf_tag;
                state_nxt  = PF;
            end
            PF: begin
                o_rom_addr = buf_tag;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
            o_ack     <= 1'b0;
            o_err     <= 1'b0;
            o_data    <= '0;
        end else begin
            state <= state_nxt;
            o_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (misaligned) begin
                            o_ack  <= 1'b1;
                            o_err  <= 1'b1;
                            o_data <= '0;
                        end else if (hit) begin
                            o_ack   <= 1'b1;
                            o_err   <= 1'b0;
                            o_data  <= buf_data;
                            buf_tag <= word_nxt;
                        end else begin
                            buf_tag   <= word_nxt;
                            buf_valid <= 1'b0;
                        end
                    end
                end
                MISS: begin
                    o_ack  <= 1'b1;
                    o_err  <= 1'b0;
                    o_data <= i_rom_data;
                end
                PF: begin
                    buf_data  <= i_rom_data;
                    buf_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boot_rom_fetch.sv
// Directed bench for boot_rom_fetch with a behavioural 1-cycle-latency ROM.
module tb_boot_rom_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] data;
    logic        err;
    logic [8:0]  rom_addr;
    logic [31:0] rom_data;

    logic [31:0] rom_mem [512];

    int checks = 0;
    int errors = 0;

    int          lat;
    logic [31:0] got_data;
    logic        got_err;

    always #5 clk = ~clk;

    boot_rom_fetch #(.ADDR_W(9)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_req      (req),
        .i_addr     (addr),
        .o_ack      (ack),
        .o_data     (data),
        .o_err      (err),
        .o_rom_addr (rom_addr),
        .i_rom_data (rom_data)
    );

    always_ff @(posedge clk) rom_data <= rom_mem[rom_addr];

    function automatic logic [31:0] rom_val(input logic [8:0] i);
        if (i == 9'd0) return 32'h0000_8137;
        if (i == 9'd1) return 32'h0101_2183;
        return (32'h9E37_79B9 * {23'd0, i}) ^ {23'd0, i};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raise a request and count rising edges until the ack; req is left high.
    task automatic fetch(input logic [31:0] a, output int l, output logic [31:0] d, output logic e);
        req  = 1'b1;
        addr = a;
        l    = 0;
        d    = 'x;
        e    = 1'bx;
        while (l < 20) begin
            @(posedge clk);
            #1;
            l++;
            if (ack) begin
                d = data;
                e = err;
                break;
            end
        end
        if (!ack) l = 99;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) rom_mem[i] = rom_val(9'(i));
        rst  = 1'b1;
        req  = 1'b0;
        addr = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);

        // First fetch misses, the sequential one hits the prefetch.
        idle(2);
        fetch(32'h000, lat, got_data, got_err);
        chk("miss0_lat", lat, 2);
        chk("miss0_data", got_data, 32'h0000_8137);
        chk("miss0_err", {31'd0, got_err}, 32'd0);
        idle(1);
        fetch(32'h004, lat, got_data, got_err);
        chk("hit1_lat", lat, 1);
        chk("hit1_data", got_data, 32'h0101_2183);

        // Back-to-back stream: one ack every 2 cycles after the first word.
        idle(2);
        fetch(32'h000, lat, got_data, got_err);
        chk("strm0_lat", lat, 2);
        chk("strm0_data", got_data, rom_val(9'd0));
        for (int k = 1; k < 16; k++) begin
            fetch(32'(k * 4), lat, got_data, got_err);
            chk($sformatf("strm%0d_lat", k), lat, 2);
            chk($sformatf("strm%0d_data", k), got_data, rom_val(9'(k)));
        end

        // Word 511 prefetches wrapped word 0.
        idle(2);
        fetch(32'h7FC, lat, got_data, got_err);
        chk("w511_lat", lat, 2);
        chk("w511_data", got_data, rom_val(9'd511));
        idle(2);
        fetch(32'h000, lat, got_data, got_err);
        chk("wrap_lat", lat, 1);
        chk("wrap_data", got_data, rom_val(9'd0));

        // Misaligned fetch, req held through the ack; buffer (word 1) survives.
        idle(2);
        fetch(32'h002, lat, got_data, got_err);
        chk("mis_lat", lat, 1);
        chk("mis_err", {31'd0, got_err}, 32'd1);
        chk("mis_data", got_data, 32'd0);
        @(posedge clk);
        #1;
        chk("mis_nodup_ack", {31'd0, ack}, 32'd0);
        idle(1);
        fetch(32'h004, lat, got_data, got_err);
        chk("afmis_lat", lat, 1);
        chk("afmis_data", got_data, rom_val(9'd1));
        chk("afmis_err", {31'd0, got_err}, 32'd0);

        // Non-sequential jump misses; no duplicate ack while req stays high.
        idle(2);
        fetch(32'h010, lat, got_data, got_err);
        chk("w4_lat", lat, 2);
        chk("w4_data", got_data, rom_val(9'd4));
        idle(1);
        fetch(32'h100, lat, got_data, got_err);
        chk("jump_lat", lat, 2);
        chk("jump_data", got_data, rom_val(9'h40));
        @(posedge clk);
        #1;
        chk("jump_nodup_ack", {31'd0, ack}, 32'd0);

        // Reset while in MISS drops the fetch; the reissue misses again.
        idle(2);
        req  = 1'b1;
        addr = 32'h200;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rstmiss_ack", {31'd0, ack}, 32'd0);
        chk("rstmiss_data", data, 32'd0);
        chk("rstmiss_err", {31'd0, err}, 32'd0);
        fetch(32'h200, lat, got_data, got_err);
        chk("reiss_lat", lat, 2);
        chk("reiss_data", got_data, rom_val(9'd128));
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
